// File: rtl/multitap_keypad_if.sv
// Consumer-side bundle of the multi-tap keypad: committed-letter handshake,
// live preview of the pending letter and the one-cycle event pulses.
interface multitap_keypad_if;
    logic [7:0] out_letter;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] preview;
    logic       tap_active;
    logic       submit;
    logic       clear;
    logic       error;

    modport master (
        output out_letter,
        output out_valid,
        input  out_ready,
        output preview,
        output tap_active,
        output submit,
        output clear,
        output error
    );

    modport slave (
        input  out_letter,
        input  out_valid,
        output out_ready,
        input  preview,
        input  tap_active,
        input  submit,
        input  clear,
        input  error
    );
endinterface

// File: rtl/multitap_keypad.sv
// Multi-tap (phone-style) text entry from a scanned ROWSxCOLS key matrix.
// Columns are driven one-hot in turn; a sensed row is debounced into a single
// key event, which drives the pending-letter logic. Committed letters are
// offered on a valid/ready output that holds one letter and drops overflow.
module multitap_keypad #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int SCAN_CYCLES = 4,
    parameter int DEBOUNCE    = 8,
    parameter int TAP_TIMEOUT = 1000,
    parameter int TAPS        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS-1:0]      row_in,
    output logic [COLS-1:0]      col_out,
    multitap_keypad_if.master    bus
);

    localparam int NKEYS    = ROWS * COLS;
    localparam int KEY_W    = $clog2(NKEYS);
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SCAN_W   = $clog2(SCAN_CYCLES + 1);
    localparam int DB_W     = $clog2(DEBOUNCE + 1);
    localparam int TO_W     = $clog2(TAP_TIMEOUT + 1);
    localparam int TAP_W    = $clog2(TAPS + 1);
    localparam int SUBMIT_K = NKEYS - 1;
    localparam int CLEAR_K  = NKEYS - 2;
    localparam int LET_RAW  = (26 + TAPS - 1) / TAPS;
    localparam int NLET     = (LET_RAW < CLEAR_K) ? LET_RAW : CLEAR_K;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_HELD     = 2'd2,
        ST_DB_REL   = 2'd3
    } state_t;

    // Number of letters on key k (the last letter key may carry fewer).
    function automatic logic [TAP_W-1:0] n_taps(input logic [KEY_W-1:0] k);
        int n;
        n = 26 - int'(k) * TAPS;
        n = (n > TAPS) ? TAPS : n;
        n = (n < 1) ? 1 : n;
        return TAP_W'(n);
    endfunction

    // ASCII code of tap t on letter key k.
    function automatic logic [7:0] letter_of(input logic [KEY_W-1:0] k,
                                             input logic [TAP_W-1:0] t);
        return 8'(32'd65 + 32'(int'(k) * TAPS) + 32'(t));
    endfunction

    state_t             state_q,      state_d;
    logic [COL_W-1:0]   col_idx_q,    col_idx_d;
    logic [COLS-1:0]    col_out_q,    col_out_d;
    logic [SCAN_W-1:0]  scan_cnt_q,   scan_cnt_d;
    logic [ROW_W-1:0]   row_q,        row_d;
    logic [DB_W-1:0]    db_cnt_q,     db_cnt_d;
    logic [KEY_W-1:0]   key_q,        key_d;
    logic [TAP_W-1:0]   tap_q,        tap_d;
    logic               tap_active_q, tap_active_d;
    logic [TO_W-1:0]    to_cnt_q,     to_cnt_d;
    logic [7:0]         out_letter_q, out_letter_d;
    logic               out_valid_q,  out_valid_d;
    logic [7:0]         preview_q,    preview_d;
    logic               submit_q,     submit_d;
    logic               clear_q,      clear_d;
    logic               error_q,      error_d;

    logic [ROW_W-1:0]   low_row_s;
    logic               row_hit_s;
    logic [KEY_W-1:0]   ev_key_s;
    logic               ev_s;
    logic               commit_s;

    // Priority-encode the lowest active row and sense the captured row.
    always_comb begin
        low_row_s = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            low_row_s = row_in[i] ? ROW_W'(i) : low_row_s;
        end
        row_hit_s = row_in[row_q];
        ev_key_s  = KEY_W'(int'(row_q) * COLS + int'(col_idx_q));
    end

    // Next-state logic: scan/debounce FSM, pending-letter handling, output slot.
    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        scan_cnt_d   = scan_cnt_q;
        row_d        = row_q;
        db_cnt_d     = db_cnt_q;
        key_d        = key_q;
        tap_d        = tap_q;
        tap_active_d = tap_active_q;
        to_cnt_d     = to_cnt_q;
        out_letter_d = out_letter_q;
        out_valid_d  = out_valid_q;
        submit_d     = 1'b0;
        clear_d      = 1'b0;
        error_d      = 1'b0;
        ev_s         = 1'b0;
        commit_s     = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (|row_in) begin
                    row_d    = low_row_s;
                    db_cnt_d = '0;
                    state_d  = ST_DB_PRESS;
                end else if (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
                    scan_cnt_d = '0;
                    col_idx_d  = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            ST_DB_PRESS: begin
                if (!row_hit_s) begin
                    db_cnt_d = '0;
                    state_d  = ST_SCAN;
                end else if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                    db_cnt_d = '0;
                    ev_s     = 1'b1;
                    state_d  = ST_HELD;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_HELD: begin
                if (!row_hit_s) begin
                    db_cnt_d = '0;
                    state_d  = ST_DB_REL;
                end else begin
                    db_cnt_d = '0;
                end
            end
            ST_DB_REL: begin
                if (row_hit_s) begin
                    db_cnt_d = '0;
                    state_d  = ST_HELD;
                end else if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                    db_cnt_d = '0;
                    state_d  = ST_SCAN;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                db_cnt_d = '0;
                state_d  = ST_SCAN;
            end
        endcase

        // Key events take precedence over the idle timeout.
        if (ev_s) begin
            to_cnt_d = '0;
            if (ev_key_s < KEY_W'(NLET)) begin
                if (tap_active_q && (ev_key_s == key_q)) begin
                    tap_d = (tap_q == n_taps(key_q) - TAP_W'(1)) ? '0 : tap_q + TAP_W'(1);
                end else begin
                    commit_s     = tap_active_q;
                    key_d        = ev_key_s;
                    tap_d        = '0;
                    tap_active_d = 1'b1;
                end
            end else if (ev_key_s == KEY_W'(SUBMIT_K)) begin
                commit_s     = tap_active_q;
                tap_active_d = 1'b0;
                submit_d     = 1'b1;
            end else if (ev_key_s == KEY_W'(CLEAR_K)) begin
                tap_active_d = 1'b0;
                clear_d      = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end else if (tap_active_q) begin
            if (to_cnt_q == TO_W'(TAP_TIMEOUT - 1)) begin
                commit_s     = 1'b1;
                tap_active_d = 1'b0;
                to_cnt_d     = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end

        // Single-entry output slot: a commit into a full, stalled slot is lost.
        if (commit_s) begin
            if (!out_valid_q || bus.out_ready) begin
                out_letter_d = letter_of(key_q, tap_q);
                out_valid_d  = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        col_out_d = COLS'(1) << col_idx_d;
        preview_d = tap_active_d ? letter_of(key_d, tap_d) : 8'h20;
    end

    // State register with synchronous reset that aborts any debounce or pending letter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SCAN;
            col_idx_q    <= '0;
            col_out_q    <= COLS'(1);
            scan_cnt_q   <= '0;
            row_q        <= '0;
            db_cnt_q     <= '0;
            key_q        <= '0;
            tap_q        <= '0;
            tap_active_q <= 1'b0;
            to_cnt_q     <= '0;
            out_letter_q <= 8'h00;
            out_valid_q  <= 1'b0;
            preview_q    <= 8'h20;
            submit_q     <= 1'b0;
            clear_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            col_out_q    <= col_out_d;
            scan_cnt_q   <= scan_cnt_d;
            row_q        <= row_d;
            db_cnt_q     <= db_cnt_d;
            key_q        <= key_d;
            tap_q        <= tap_d;
            tap_active_q <= tap_active_d;
            to_cnt_q     <= to_cnt_d;
            out_letter_q <= out_letter_d;
            out_valid_q  <= out_valid_d;
            preview_q    <= preview_d;
            submit_q     <= submit_d;
            clear_q      <= clear_d;
            error_q      <= error_d;
        end
    end

    assign col_out        = col_out_q;
    assign bus.out_letter = out_letter_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.preview    = preview_q;
    assign bus.tap_active = tap_active_q;
    assign bus.submit     = submit_q;
    assign bus.clear      = clear_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_multitap_keypad.sv
// Directed bench for multitap_keypad with a 4x4 matrix model: a pressed key
// pulls its row high only while its column is driven.
module tb_multitap_keypad;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       raw_mode;
    logic [3:0] row_drv;
    logic       press_en;
    int         pr;
    int         pc;

    int n_tests = 0;
    int n_fail  = 0;
    int n_submit = 0;
    int n_clear  = 0;
    int n_error  = 0;
    logic [7:0] submit_letter = 8'h00;
    logic       submit_valid  = 1'b0;

    multitap_keypad_if bus ();

    multitap_keypad #(
        .ROWS(4), .COLS(4), .SCAN_CYCLES(4), .DEBOUNCE(8), .TAP_TIMEOUT(1000), .TAPS(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .col_out (col_out),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign row_in = raw_mode ? row_drv
                  : ((press_en && col_out[pc]) ? (4'b0001 << pr) : 4'b0000);

    // Count pulse cycles and capture the output slot when submit fires.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.submit === 1'b1) begin
                n_submit      <= n_submit + 1;
                submit_letter <= bus.out_letter;
                submit_valid  <= bus.out_valid;
            end
            if (bus.clear === 1'b1) n_clear <= n_clear + 1;
            if (bus.error === 1'b1) n_error <= n_error + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold key k long enough to be scanned and debounced, then release it fully.
    task automatic press(input int k);
        pr = k / 4;
        pc = k % 4;
        press_en = 1'b1;
        repeat (40) tick();
        press_en = 1'b0;
        repeat (30) tick();
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    int e0;
    int s0;
    int c0;
    int waited;

    initial begin
        rst = 1'b1;
        raw_mode = 1'b1;
        row_drv = 4'b0001;
        press_en = 1'b0;
        pr = 0;
        pc = 0;
        bus.out_ready = 1'b0;

        // Reset with a row asserted.
        repeat (2) tick();
        check("rst_col_out",  32'(col_out),        32'h1);
        check("rst_valid",    32'(bus.out_valid),  32'h0);
        check("rst_letter",   32'(bus.out_letter), 32'h0);
        check("rst_preview",  32'(bus.preview),    32'h20);
        check("rst_tap",      32'(bus.tap_active), 32'h0);
        check("rst_pulses",   32'({bus.submit, bus.clear, bus.error}), 32'h0);
        row_drv = 4'b0000;
        raw_mode = 1'b0;
        rst = 1'b0;
        repeat (5) tick();

        // Multi-tap on key 3 with idle timeout commit.
        press(3);
        check("mt_preview_J", 32'(bus.preview),    32'h4A);
        check("mt_tap_active", 32'(bus.tap_active), 32'h1);
        press(3);
        check("mt_preview_K", 32'(bus.preview),    32'h4B);
        press(3);
        check("mt_preview_L", 32'(bus.preview),    32'h4C);
        check("mt_no_commit_yet", 32'(bus.out_valid), 32'h0);
        repeat (900) tick();
        check("mt_not_early", 32'(bus.out_valid),  32'h0);
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        check("mt_timeout_valid", 32'(bus.out_valid),  32'h1);
        check("mt_timeout_letter", 32'(bus.out_letter), 32'h4C);
        check("mt_tap_cleared",   32'(bus.tap_active), 32'h0);
        check("mt_preview_blank", 32'(bus.preview),    32'h20);
        repeat (5) tick();
        check("mt_valid_held",    32'(bus.out_valid),  32'h1);
        consume();
        check("mt_valid_dropped", 32'(bus.out_valid),  32'h0);

        // Two-letter key wraps, then submit commits it.
        s0 = n_submit;
        press(8);
        check("wrap_Y", 32'(bus.preview), 32'h59);
        press(8);
        check("wrap_Z", 32'(bus.preview), 32'h5A);
        press(8);
        check("wrap_Y_again", 32'(bus.preview), 32'h59);
        press(15);
        check("sub_pulses",    32'(n_submit - s0),   32'd1);
        check("sub_same_cyc_letter", 32'(submit_letter), 32'h59);
        check("sub_same_cyc_valid",  32'(submit_valid),  32'h1);
        check("sub_letter",    32'(bus.out_letter),  32'h59);
        check("sub_tap",       32'(bus.tap_active),  32'h0);
        check("sub_preview",   32'(bus.preview),     32'h20);
        consume();

        // Unmapped key only pulses error.
        e0 = n_error;
        press(9);
        check("unmapped_error", 32'(n_error - e0),   32'd1);
        check("unmapped_tap",   32'(bus.tap_active), 32'h0);
        check("unmapped_valid", 32'(bus.out_valid),  32'h0);

        // Bounce shorter than the debounce window.
        e0 = n_error;
        raw_mode = 1'b1;
        row_drv = 4'b0001;
        repeat (5) tick();
        row_drv = 4'b0000;
        repeat (20) tick();
        raw_mode = 1'b0;
        check("bounce_preview", 32'(bus.preview),    32'h20);
        check("bounce_tap",     32'(bus.tap_active), 32'h0);
        check("bounce_no_err",  32'(n_error - e0),   32'd0);

        // Backpressure: second commit into a stalled slot is dropped.
        e0 = n_error;
        press(0);
        press(1);
        check("bp_first_valid",  32'(bus.out_valid),  32'h1);
        check("bp_first_letter", 32'(bus.out_letter), 32'h41);
        check("bp_preview_D",    32'(bus.preview),    32'h44);
        press(15);
        check("bp_letter_kept",  32'(bus.out_letter), 32'h41);
        check("bp_error_once",   32'(n_error - e0),   32'd1);
        check("bp_valid_kept",   32'(bus.out_valid),  32'h1);
        consume();

        // Commit on key switch, then clear discards the pending letter.
        press(0);
        press(1);
        check("sw_letter_A",  32'(bus.out_letter), 32'h41);
        check("sw_preview_D", 32'(bus.preview),    32'h44);
        consume();
        check("sw_consumed",  32'(bus.out_valid),  32'h0);
        c0 = n_clear;
        press(14);
        check("clr_pulse",    32'(n_clear - c0),   32'd1);
        check("clr_tap",      32'(bus.tap_active), 32'h0);
        check("clr_preview",  32'(bus.preview),    32'h20);
        repeat (1100) tick();
        check("clr_no_commit", 32'(bus.out_valid), 32'h0);

        // Reset aborts a pending letter without committing it.
        press(4);
        check("rab_pending", 32'(bus.preview), 32'h4D);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rab_tap",     32'(bus.tap_active), 32'h0);
        check("rab_preview", 32'(bus.preview),    32'h20);
        repeat (1100) tick();
        check("rab_no_commit", 32'(bus.out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multitap_keypad.md
MULTITAP_KEYPAD -- requirements
Module: multitap_keypad

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad rows sensed.
REQ-002 SHALL have parameter COLS, default 4, number of keypad columns driven.
REQ-003 SHALL have parameter SCAN_CYCLES, default 4, cycles each column is driven while scanning.
REQ-004 SHALL have parameter DEBOUNCE, default 8, consecutive stable cycles needed to accept a press or release.
REQ-005 SHALL have parameter TAP_TIMEOUT, default 1000, idle cycles before a pending letter auto-commits.
REQ-006 SHALL have parameter TAPS, default 3, maximum letters per key.
REQ-007 SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst  in  1  synchronous active-high reset.
REQ-009 SHALL have port row_in  in  ROWS  row sense, bit r high = row r active.
REQ-010 SHALL have port col_out  out  COLS  one-hot column drive.
REQ-011 SHALL have port out_letter  out  8  committed ASCII letter.
REQ-012 SHALL have port out_valid  out  1  out_letter valid.
REQ-013 SHALL have port out_ready  in  1  consumer accepts out_letter.
REQ-014 SHALL have port preview  out  8  ASCII of pending letter, 8'h20 when none.
REQ-015 SHALL have port tap_active  out  1  letter pending.
REQ-016 SHALL have ports submit, clear, error  out  1 each  one-cycle pulses.

Function
REQ-017 SHALL define key index k = r*COLS + c; SUBMIT = ROWS*COLS-1; CLEAR = ROWS*COLS-2; letter keys k < min(ceil(26/TAPS), CLEAR); all other k unmapped.
REQ-018 SHALL give letter key k n_k = min(TAPS, 26 - k*TAPS) letters, tap t mapping to ASCII 'A' + k*TAPS + t.
REQ-019 SHALL implement key FSM states SCAN, DB_PRESS, HELD, DB_REL.
REQ-020 SHALL, in SCAN, advance col_out one position every SCAN_CYCLES cycles, wrapping COLS-1 to 0; col_out SHALL hold in all other states.
REQ-021 SHALL, in SCAN with any row_in bit high, capture the lowest set row and the current column, then go to DB_PRESS.
REQ-022 SHALL, in DB_PRESS, emit one internal key event and go to HELD after DEBOUNCE consecutive high cycles of the captured row; if the row drops first, SHALL return to SCAN with no event.
REQ-023 SHALL go from HELD to DB_REL when the captured row goes low; DB_REL SHALL go to SCAN after DEBOUNCE consecutive low cycles, or back to HELD if the row goes high.
REQ-024 SHALL handle a letter key event for the pending key while tap_active as tap = (tap+1) mod n_k.
REQ-025 SHALL handle any other letter key event by committing the pending letter if tap_active, then setting pending key = k, tap = 0, tap_active = 1.
REQ-026 SHALL handle a SUBMIT event by committing the pending letter if any, clearing tap_active, and pulsing submit in the same cycle the commit loads.
REQ-027 SHALL handle a CLEAR event by discarding the pending letter, clearing tap_active, and pulsing clear; no commit SHALL occur.
REQ-028 SHALL handle an unmapped key event by pulsing error only, with no other effect.
REQ-029 SHALL run the timeout counter ($clog2(TAP_TIMEOUT+1) bits) while tap_active, zero it on every key event, and commit and clear tap_active when it reaches TAP_TIMEOUT-1.
REQ-030 SHALL, on a commit with out_valid=0 or out_ready=1, load out_letter and set out_valid=1 on the next edge.
REQ-031 SHALL, on a commit with out_valid=1 and out_ready=0, drop the letter, pulse error, and leave out_letter unchanged.
REQ-032 SHALL clear out_valid after an out_valid && out_ready cycle unless a commit loads in that same cycle.
REQ-033 SHALL update preview, tap_active and all pulses on the edge following the event.

Reset
REQ-034 SHALL, while rst is high at an edge, set FSM=SCAN, col_out=1, out_letter=0, out_valid=0, preview=8'h20, tap_active=0, submit=clear=error=0, and all counters to 0.
REQ-035 SHALL make reset override every event, and SHALL abort a debounce or pending letter in progress with no commit.

Verification
REQ-036 SHALL test reset: rst high 2 cycles with row_in=4'b0001 -> col_out=4'b0001, out_valid=0, preview=8'h20, no pulses.
REQ-037 SHALL test multi-tap with timeout: key 3 (r0c3) tapped 3x -> preview 'J','K','L'; TAP_TIMEOUT cycles later out_letter=8'h4C, out_valid=1 held until out_ready.
REQ-038 SHALL test short-key wrap and submit: key 8 (r2c0) tapped 3x, then key 15 -> out_letter=8'h59 ('Y'), submit pulses 1 cycle.
REQ-039 SHALL test bounce rejection: row high 5 cycles then low -> no event, preview=8'h20, tap_active=0.
REQ-040 SHALL test backpressure: out_ready=0, commit 'A' then 'D' -> out_letter stays 8'h41, error pulses once.
REQ-041 SHALL test commit-on-switch and clear: key 0 then key 1 -> 'A' committed, preview 'D'; then key 14 -> clear pulses, 'D' not committed.
